// File: rtl/led_pattern_ctrl.sv
// LED bank scheduler: one programmable divider yields a single-cycle step enable,
// and a four-mode pattern engine advances the LED bank on each step.
module led_pattern_ctrl #(
  parameter int CLK_HZ = 50_000_000,
  parameter int N_LEDS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        rate_sel,
  input  logic              pause,
  input  logic              btn_mode,
  output logic [N_LEDS-1:0] leds,
  output logic              tick,
  output logic [1:0]        mode
);

  localparam int CW = $clog2(CLK_HZ);
  localparam logic [CW-1:0]     TERM_1HZ   = CW'(CLK_HZ - 1);
  localparam logic [CW-1:0]     TERM_10HZ  = CW'(CLK_HZ / 10 - 1);
  localparam logic [CW-1:0]     TERM_100HZ = CW'(CLK_HZ / 100 - 1);
  localparam logic [N_LEDS-1:0] LED_ZERO   = {N_LEDS{1'b0}};
  localparam logic [N_LEDS-1:0] LED_ONE    = {{(N_LEDS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    BLINK  = 2'd0,
    SHIFT  = 2'd1,
    BOUNCE = 2'd2,
    COUNT  = 2'd3
  } mode_e;

  mode_e             mode_q, mode_d;
  logic [CW-1:0]     count_q, count_d;
  logic [N_LEDS-1:0] leds_q, leds_d;
  logic              tick_q, tick_d;
  logic              dir_up_q, dir_up_d;
  logic              btn_q;
  logic [1:0]        rate_q;

  logic [CW-1:0]     term_s;
  logic [N_LEDS-1:0] step_s;
  logic              step_dir_s;
  logic              btn_edge_s;
  logic              rate_chg_s;

  function automatic logic [CW-1:0] term_of(input logic [1:0] sel);
    case (sel)
      2'b01:   return TERM_10HZ;
      2'b10:   return TERM_100HZ;
      default: return TERM_1HZ;
    endcase
  endfunction

  function automatic logic [N_LEDS-1:0] init_pattern(input mode_e m);
    case (m)
      SHIFT, BOUNCE: return LED_ONE;
      default:       return LED_ZERO;
    endcase
  endfunction

  assign term_s     = term_of(rate_q);
  assign btn_edge_s = btn_mode & ~btn_q;
  assign rate_chg_s = (rate_sel != rate_q);

  // Pattern one step ahead; bounce flips direction on the step that lands on an end LED.
  always_comb begin
    step_s     = leds_q;
    step_dir_s = dir_up_q;
    case (mode_q)
      BLINK: step_s = ~leds_q;
      SHIFT: step_s = {leds_q[N_LEDS-2:0], leds_q[N_LEDS-1]};
      BOUNCE: begin
        if (dir_up_q) begin
          step_s     = {leds_q[N_LEDS-2:0], 1'b0};
          step_dir_s = ~leds_q[N_LEDS-2];
        end else begin
          step_s     = {1'b0, leds_q[N_LEDS-1:1]};
          step_dir_s = leds_q[1];
        end
      end
      COUNT:   step_s = leds_q + LED_ONE;
      default: step_s = leds_q;
    endcase
  end

  // Next state: button advance beats a rate change, which beats the divider step.
  always_comb begin
    mode_d   = mode_q;
    count_d  = count_q;
    leds_d   = leds_q;
    dir_up_d = dir_up_q;
    tick_d   = 1'b0;
    if (btn_edge_s) begin
      mode_d   = mode_e'(mode_q + 2'd1);
      count_d  = '0;
      dir_up_d = 1'b1;
      leds_d   = init_pattern(mode_e'(mode_q + 2'd1));
    end else if (rate_chg_s) begin
      count_d = '0;
    end else if (pause) begin
      count_d = count_q;
    end else if (count_q == term_s) begin
      count_d  = '0;
      tick_d   = 1'b1;
      leds_d   = step_s;
      dir_up_d = step_dir_s;
    end else begin
      count_d = count_q + CW'(1);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q   <= BLINK;
      count_q  <= '0;
      leds_q   <= LED_ZERO;
      tick_q   <= 1'b0;
      dir_up_q <= 1'b1;
      btn_q    <= 1'b0;
      rate_q   <= rate_sel;
    end else begin
      mode_q   <= mode_d;
      count_q  <= count_d;
      leds_q   <= leds_d;
      tick_q   <= tick_d;
      dir_up_q <= dir_up_d;
      btn_q    <= btn_mode;
      rate_q   <= rate_sel;
    end
  end

  assign leds = leds_q;
  assign tick = tick_q;
  assign mode = mode_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Scoreboard bench for led_pattern_ctrl: a behavioural model predicts every cycle's
// outputs into a queue and a monitor compares them against the DUT.
module tb_led_pattern_ctrl;

  localparam int CLK_HZ = 1000;
  localparam int N      = 4;

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b0;
  logic [1:0]   rate_sel = 2'd2;
  logic         pause    = 1'b0;
  logic         btn_mode = 1'b0;
  logic [N-1:0] leds;
  logic         tick;
  logic [1:0]   mode;

  led_pattern_ctrl #(.CLK_HZ(CLK_HZ), .N_LEDS(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rate_sel (rate_sel),
    .pause    (pause),
    .btn_mode (btn_mode),
    .leds     (leds),
    .tick     (tick),
    .mode     (mode)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         tick;
    logic [1:0]   mode;
    logic [N-1:0] leds;
  } obs_t;

  obs_t exp_q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   tick_seen = 0;
  int   cyc_no    = 0;
  bit   started   = 0;

  // Reference model: phase within the current period plus per-mode pattern indices.
  int m_mode, m_phase, m_rate, m_blink, m_shift, m_sweep, m_cnt;
  bit m_btn, m_tick;

  function automatic int period_of(int r);
    case (r)
      1:       return CLK_HZ / 10;
      2:       return CLK_HZ / 100;
      default: return CLK_HZ;
    endcase
  endfunction

  function automatic logic [N-1:0] model_leds();
    int pos;
    case (m_mode)
      0: return m_blink ? {N{1'b1}} : {N{1'b0}};
      1: return N'(1 << m_shift);
      2: begin
        pos = (m_sweep < N) ? m_sweep : (2 * N - 2 - m_sweep);
        return N'(1 << pos);
      end
      default: return N'(m_cnt);
    endcase
  endfunction

  task automatic reset_pattern();
    m_blink = 0; m_shift = 0; m_sweep = 0; m_cnt = 0;
  endtask

  task automatic advance_pattern();
    case (m_mode)
      0: m_blink = !m_blink;
      1: m_shift = (m_shift + 1) % N;
      2: m_sweep = (m_sweep + 1) % (2 * N - 2);
      default: m_cnt = (m_cnt + 1) % (1 << N);
    endcase
  endtask

  task automatic model_step(bit r, int rt, bit p, bit b);
    bit is_edge;
    if (!r) begin
      m_mode = 0; m_phase = 0; m_tick = 0; m_btn = 0; m_rate = rt;
      reset_pattern();
    end else begin
      is_edge = b && !m_btn;
      m_tick  = 0;
      if (is_edge) begin
        m_mode  = (m_mode + 1) % 4;
        m_phase = 0;
        reset_pattern();
      end else if (rt != m_rate) begin
        m_phase = 0;
      end else if (!p) begin
        if (m_phase == period_of(m_rate) - 1) begin
          m_phase = 0;
          m_tick  = 1;
          advance_pattern();
        end else begin
          m_phase++;
        end
      end
      m_btn  = b;
      m_rate = rt;
    end
  endtask

  // One clock of stimulus: drive at the falling edge, predict the next rising edge.
  task automatic cycle(bit r, int rt, bit p, bit b);
    obs_t e;
    @(negedge clk);
    rst_n = r; rate_sel = 2'(rt); pause = p; btn_mode = b;
    model_step(r, rt, p, b);
    e.tick = m_tick; e.mode = 2'(m_mode); e.leds = model_leds();
    exp_q.push_back(e);
    started = 1;
  endtask

  task automatic run(int n, int rt);
    for (int i = 0; i < n; i++) cycle(1, rt, 0, 0);
  endtask

  task automatic press(int rt);
    cycle(1, rt, 0, 1);
    cycle(1, rt, 0, 0);
  endtask

  // Monitor: pops one prediction per rising edge and compares all outputs.
  initial begin
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc_no++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({tick, mode, leds} !== e) begin
          errors++;
          $display("FAIL scoreboard cycle %0d: got tick=%b mode=%0d leds=%b, expected tick=%b mode=%0d leds=%b",
                   cyc_no, tick, mode, leds, e.tick, e.mode, e.leds);
        end
        if (tick === 1'b1) tick_seen++;
      end else if (started) begin
        checks++;
        errors++;
        $display("FAIL underflow cycle %0d: DUT output with no prediction queued", cyc_no);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    int guard;
    int rt;
    bit b;
    // Reset, then 10 ms steps in BLINK: ticks after release edges 10, 20, 30.
    for (int i = 0; i < 3; i++) cycle(0, 2, 0, 0);
    run(35, 2);
    checks++;
    if (tick_seen != 3) begin
      errors++;
      $display("FAIL first_ticks: got %0d ticks, expected 3", tick_seen);
    end
    // Held button: exactly one advance to SHIFT.
    for (int i = 0; i < 5; i++) cycle(1, 2, 0, 1);
    run(45, 2);
    checks++;
    if (mode !== 2'd1) begin
      errors++;
      $display("FAIL held_button: got mode %0d, expected 1", mode);
    end
    // BOUNCE sweep, then COUNT through a full wrap.
    press(2);
    run(85, 2);
    press(2);
    run(175, 2);
    // Pause mid-count.
    run(4, 2);
    for (int i = 0; i < 25; i++) cycle(1, 2, 1, 0);
    run(30, 2);
    // Rate change exactly when the divider sits at its terminal value.
    guard = 0;
    while (m_phase != 9 && guard < 20) begin cycle(1, 2, 0, 0); guard++; end
    cycle(1, 1, 0, 0);
    run(110, 1);
    // Button edge on the same edge as a tick.
    cycle(1, 2, 0, 0);
    guard = 0;
    while (m_phase != 9 && guard < 20) begin cycle(1, 2, 0, 0); guard++; end
    cycle(1, 2, 0, 1);
    run(15, 2);
    // Reset in the middle of a BOUNCE sweep.
    press(2);
    press(2);
    run(47, 2);
    cycle(0, 2, 0, 0);
    run(20, 2);
    // Randomised mix of rates, pauses, button presses and rare resets.
    rt = 2;
    b  = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) rt = $urandom_range(0, 3);
      if ($urandom_range(0, 39) == 0) b = ~b;
      if ($urandom_range(0, 1499) == 0) cycle(0, rt, 0, 0);
      else cycle(1, rt, ($urandom_range(0, 9) == 0), b);
    end
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
- Scheduler for the board LED bank, driven from the 50 MHz board clock.
- Replaces the free-running divider-toggle scheme with a single-clock design: one programmable divider produces a one-cycle tick enable, and a mode FSM advances an LED pattern on each tick.
- Tick rate (1/10/100 Hz), pattern mode and pause are controlled from board switches and a button.
- No derived clocks: every register runs on clk.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency in Hz. Must be a multiple of 100 and at least 100.
- N_LEDS, 8, width of the LED bank. Must be at least 2.

Ports:
- clk  in  1  board clock.
- rst_n  in  1  synchronous reset, active-low.
- rate_sel  in  2  step rate: 00 = 1 Hz, 01 = 10 Hz, 10 = 100 Hz, 11 = 1 Hz.
- pause  in  1  1 = freeze the divider and pattern.
- btn_mode  in  1  mode-advance button. Already synchronised and debounced, level high while pressed.
- leds  out  N_LEDS  LED pattern, registered.
- tick  out  1  one-cycle pulse marking each pattern step, registered.
- mode  out  2  current mode: 0 = BLINK, 1 = SHIFT, 2 = BOUNCE, 3 = COUNT.

Behaviour:
- Reset (rst_n low at a clk edge) sets: leds = 0, tick = 0, mode = BLINK, divider count = 0, bounce direction = up, btn_q = 0, rate_q = rate_sel.
- Divisor DIV = CLK_HZ / rate, where rate is the frequency selected by rate_sel.
- Divider count width is $clog2(CLK_HZ).
- Count runs 0 to DIV-1 and wraps to 0.
- At any edge where count == DIV-1 and pause == 0:
  - count <= 0 and tick <= 1, in the same edge as the LED update.
  - All other edges: tick <= 0.
- First tick after reset release: the count is DIV-1 at edge DIV (reset release = edge 0), so tick goes high during the cycle following edge DIV.
- pause == 1: count holds, tick stays 0, leds hold, mode changes are still accepted.
- Rate change:
  - rate_q registers rate_sel.
  - An edge where rate_sel != rate_q sets count <= 0 and produces no tick, even if the count was at DIV-1.
  - The new divisor applies from the next cycle.
- Button edge:
  - btn_edge = btn_mode & ~btn_q; btn_q registers btn_mode.
  - On a btn_edge edge: mode <= mode+1, wrapping 3 -> 0; count <= 0; tick <= 0; leds <= initial pattern of the new mode.
  - A held button produces one advance only.
- Priority at the same edge: reset > btn_edge > rate change > tick step.
- Initial patterns:
  - BLINK: all 0.
  - SHIFT: bit 0 set.
  - BOUNCE: bit 0 set, direction up.
  - COUNT: 0.
- Step rules, applied on the tick edge:
  - BLINK: leds <= ~leds.
  - SHIFT: rotate left by 1; bit N-1 wraps to bit 0.
  - BOUNCE: one-hot position moves one step in the current direction. On reaching bit N-1 the direction becomes down; on reaching bit 0 it becomes up. The end LED is shown once per sweep, with no repeated end state.
  - COUNT: leds <= leds + 1, modulo 2^N_LEDS, wrapping all-ones -> 0.
- Illegal leds contents are not reachable; no recovery logic is required.
- Reset mid-pattern: the block returns to the reset values at that edge, including mode = BLINK.

Test Plan (CLK_HZ=1000, N_LEDS=4, so divisors are 1000 / 100 / 10):
- Reset, then rate_sel=10 -> tick high exactly at cycles 10, 20, 30 after release; BLINK leds go 0000 -> 1111 -> 0000.
- One btn_mode pulse, held for 5 cycles, rate=10 -> mode=1 and leds=0001 at the edge the button is first seen, only one advance; after ticks leds = 0010, 0100, 1000, 0001.
- Advance to BOUNCE, 8 ticks -> leds = 0010, 0100, 1000, 0100, 0010, 0001, 0010, 0100.
- Advance to COUNT, 17 ticks -> leds count 1 through 15, then 0000, then 0001.
- Pause asserted for 25 cycles in the middle of a count, then released -> no ticks and leds frozen during the pause; the next tick comes after the remaining count is consumed.
- Divider at count 9 (rate 10) and rate_sel switched to 01 at that edge -> no tick at that edge, count restarts, next tick 100 cycles later.
- btn_edge coinciding with a tick edge -> mode advances, leds = initial pattern, tick = 0.
- rst_n low for 1 cycle mid-BOUNCE -> leds=0000, mode=0, tick=0 the following cycle.
